ifetch: RTL and testbench

Instruction-fetch stage of the RV64 pipeline, directly upstream of `idecode`. It owns the program counter and issues sequential 32-bit fetches to the instruction memory port with up to two requests outstanding. It buffers returned instructions in a 2-entry queue and presents `{instr, pc}` to decode under decode's stall/flush control. On redirect it discards all in-flight and buffered instructions.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/ifetch_queue.sv | 41 ++++
 rtl/ifetch.sv | 111 +++++++++++
 tb/tb_ifetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants for the RV64 front end.
package riscv_pkg;
    localparam int XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            fault;
    } fetch_entry_t;
    typedef enum logic [1:0] {BOOT, FETCH, DRAIN, FAULT} fetch_state_t;
endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: 2-entry FIFO of fetch entries with synchronous clear.
module ifetch_queue
    import riscv_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);
    fetch_entry_t r_mem [2];
    logic         r_rd;
    logic         r_wr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop   = i_pop && r_count != 2'd0;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push && (r_count != 2'd2 || w_pop);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= !r_wr;
            end
            if (w_pop) r_rd <= !r_rd;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/ifetch.sv
// ifetch: RV64 instruction-fetch stage; owns the PC, keeps up to two fetches
// in flight and hands buffered {instr, pc} to decode.
module ifetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 64'h1000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    input  logic            i_imem_rsp_fault,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc_out,
    output logic            o_valid,
    output logic            o_fetch_fault
);
    fetch_state_t    r_state;
    fetch_state_t    w_state_nx;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_ipc [2];
    logic [1:0]      r_outstanding;
    logic [1:0]      r_discard;
    logic            r_mis;
    logic [1:0]      w_count;
    logic [1:0]      w_redir_disc;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_mis_push;
    logic            w_slot;

    assign w_fire     = o_imem_req_valid && i_imem_req_ready;
    assign w_pop      = o_valid && !i_stall;
    assign w_mis_push = r_state == FETCH && r_mis && !i_redirect;
    // Responses still owed by memory; the one arriving now is dropped with them.
    assign w_redir_disc = r_outstanding + r_discard - {1'b0, i_imem_rsp_valid};
    // Next free in-flight PC slot after this cycle's response shifts the list.
    assign w_slot     = r_outstanding[0] && !i_imem_rsp_valid;

    always_comb begin
        o_imem_req_valid = r_state == FETCH && !r_mis && !i_redirect &&
                           ({1'b0, w_count} + {1'b0, r_outstanding}) < 3'd2;
        o_imem_req_addr  = r_fetch_pc;
        w_push = !i_redirect && ((r_state == FETCH && !r_mis && i_imem_rsp_valid) || w_mis_push);
        w_push_data = w_mis_push ? {r_fetch_pc, NOP_INSTR, 1'b1}
                                 : {r_ipc[0], i_imem_rsp_data, i_imem_rsp_fault};
        o_valid       = w_count != 2'd0;
        o_instr       = o_valid ? w_head.instr : NOP_INSTR;
        o_pc_out      = o_valid ? w_head.pc : '0;
        o_fetch_fault = o_valid && w_head.fault;
    end

    always_comb begin
        w_state_nx = r_state;
        w_state_nx = r_state == BOOT ? FETCH : w_state_nx;
        w_state_nx = r_state == FETCH && (w_mis_push || (i_imem_rsp_valid && !r_mis && i_imem_rsp_fault))
                   ? FAULT : w_state_nx;
        w_state_nx = r_state == DRAIN && r_discard == 2'd0 && !i_imem_rsp_valid ? FETCH : w_state_nx;
        w_state_nx = i_redirect ? (w_redir_disc != 2'd0 ? DRAIN : FETCH) : w_state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= BOOT;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
            r_mis         <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (i_redirect) begin
                r_fetch_pc    <= i_redirect_pc;
                r_outstanding <= 2'd0;
                r_discard     <= w_redir_disc;
                r_mis         <= |i_redirect_pc[1:0];
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                r_outstanding <= r_outstanding + {1'b0, w_fire}
                               - {1'b0, i_imem_rsp_valid && r_state != DRAIN};
                if (r_state == DRAIN && i_imem_rsp_valid) r_discard <= r_discard - 2'd1;
                if (w_mis_push) r_mis <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_imem_rsp_valid) r_ipc[0] <= r_ipc[1];
        if (w_fire) r_ipc[w_slot] <= r_fetch_pc;
    end

    ifetch_queue u_queue (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed, table-driven bench for ifetch with a latency-configurable
// in-order instruction memory model.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic        ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic [31:0] instr;
    logic [63:0] pc_out;
    logic        valid;
    logic        fetch_fault;

    int          n_chk = 0;
    int          n_fail = 0;
    int          lat = 1;
    int          fire_cnt = 0;
    int          base;
    logic [63:0] fault_addr;
    logic [2:0]  p_v;
    logic [63:0] p_a [3];
    logic [63:0] ra;

    typedef struct packed {
        logic        stall;
        logic        v;
        logic [63:0] pc;
        logic        req;
        logic [63:0] addr;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = !clk;

    ifetch dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_stall          (stall),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (ready),
        .o_imem_req_addr  (req_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_imem_rsp_fault (rsp_fault),
        .o_instr          (instr),
        .o_pc_out         (pc_out),
        .o_valid          (valid),
        .o_fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h0BAD_F00D;
    endfunction

    always @(posedge clk) begin
        if (reset) p_v <= 3'b000;
        else p_v <= {p_v[1:0], req_valid && ready};
        p_a[0] <= req_addr;
        p_a[1] <= p_a[0];
        p_a[2] <= p_a[1];
        if (!reset && req_valid && ready) fire_cnt <= fire_cnt + 1;
    end

    always_comb begin
        rsp_valid = p_v[lat-1];
        ra        = p_a[lat-1];
        rsp_data  = mem_word(ra);
        rsp_fault = rsp_valid && ra == fault_addr;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_out(input string n, input logic v, input logic [63:0] pc,
                              input logic [31:0] ins, input logic f);
        chk({n, " valid"}, 64'(valid), 64'(v));
        chk({n, " pc_out"}, pc_out, pc);
        chk({n, " instr"}, 64'(instr), 64'(ins));
        chk({n, " fetch_fault"}, 64'(fetch_fault), 64'(f));
    endtask

    task automatic expect_req(input string n, input logic r, input logic [63:0] a);
        chk({n, " req_valid"}, 64'(req_valid), 64'(r));
        if (r) chk({n, " req_addr"}, req_addr, a);
    endtask

    task automatic do_reset(input int l, input logic [63:0] fa);
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        ready = 1'b1;
        lat = l;
        fault_addr = fa;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 64'h0,    1'b0, 64'h0};
        tbl[1]  = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1000};
        tbl[2]  = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1004};
        tbl[3]  = '{1'b0, 1'b1, 64'h1000, 1'b0, 64'h0};
        tbl[4]  = '{1'b1, 1'b1, 64'h1004, 1'b1, 64'h1008};
        tbl[5]  = '{1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
        tbl[6]  = '{1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
        tbl[7]  = '{1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
        tbl[8]  = '{1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
        tbl[9]  = '{1'b0, 1'b1, 64'h1004, 1'b0, 64'h0};
        tbl[10] = '{1'b0, 1'b1, 64'h1008, 1'b1, 64'h100c};
        tbl[11] = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1010};
        tbl[12] = '{1'b0, 1'b1, 64'h100c, 1'b0, 64'h0};
        tbl[13] = '{1'b0, 1'b1, 64'h1010, 1'b1, 64'h1014};

        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        ready = 1'b1;
        fault_addr = '1;
        repeat (3) @(negedge clk);
        expect_out("reset", 1'b0, 64'h0, 32'h13, 1'b0);
        expect_req("reset", 1'b0, 64'h0);
        reset = 1'b0;

        // Sequential fetch, then a 5-cycle stall filling the queue.
        for (int i = 0; i < 14; i++) begin
            stall = tbl[i].stall;
            #1;
            expect_out($sformatf("row%0d", i), tbl[i].v, tbl[i].v ? tbl[i].pc : 64'h0,
                       tbl[i].v ? mem_word(tbl[i].pc) : 32'h13, 1'b0);
            expect_req($sformatf("row%0d", i), tbl[i].req, tbl[i].addr);
            @(negedge clk);
        end

        // Memory not ready for 3 cycles: address holds.
        do_reset(1, '1);
        ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_req($sformatf("noready%0d", i), 1'b1, 64'h1000);
            @(negedge clk);
        end
        ready = 1'b1;
        #1;
        expect_req("ready_fire", 1'b1, 64'h1000);
        @(negedge clk);
        #1;
        expect_req("ready_next", 1'b1, 64'h1004);

        // Redirect with two requests outstanding (3-cycle memory).
        do_reset(3, '1);
        repeat (3) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 64'h2000;
        #1;
        expect_req("redir_same", 1'b0, 64'h0);
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_req($sformatf("drain%0d", i), 1'b0, 64'h0);
            chk($sformatf("drain%0d valid", i), 64'(valid), 64'd0);
            @(negedge clk);
        end
        #1;
        expect_req("redir_req", 1'b1, 64'h2000);
        for (int i = 0; i < 12 && !valid; i++) @(negedge clk);
        #1;
        expect_out("redir_first", 1'b1, 64'h2000, mem_word(64'h2000), 1'b0);

        // Access fault on the response for 0x1004.
        do_reset(1, 64'h1004);
        repeat (3) @(negedge clk);
        #1;
        expect_out("flt_head", 1'b1, 64'h1000, mem_word(64'h1000), 1'b0);
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_out($sformatf("flt%0d", i), 1'b1, 64'h1004, mem_word(64'h1004), 1'b1);
            expect_req($sformatf("flt%0d", i), 1'b0, 64'h0);
            @(negedge clk);
        end
        redirect = 1'b1;
        redirect_pc = 64'h3000;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("flt_redir valid", 64'(valid), 64'd0);
        expect_req("flt_redir", 1'b1, 64'h3000);

        // Misaligned redirect target.
        do_reset(1, '1);
        base = fire_cnt;
        stall = 1'b1;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 64'h2002;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        expect_req("mis_push", 1'b0, 64'h0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_out($sformatf("mis%0d", i), 1'b1, 64'h2002, 32'h13, 1'b1);
            expect_req($sformatf("mis%0d", i), 1'b0, 64'h0);
            @(negedge clk);
        end
        chk("mis fires", 64'(fire_cnt - base), 64'd0);

        // fetch_pc wraps modulo 2^64.
        do_reset(1, '1);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        expect_req("wrap_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        #1;
        expect_req("wrap_zero", 1'b1, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
